// File: rtl/systolic_pe_dual_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_pkg : shared FSM encoding, mode constants and saturating add    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pe_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WS_RUN   = 2'd1,
    OS_ACC   = 2'd2,
    OS_DRAIN = 2'd3
  } pe_state_e;

  localparam logic MODE_WS = 1'b0;
  localparam logic MODE_OS = 1'b1;

  // Operands arrive sign-extended to 64 bits; w is the target width (<= 62),
  // so the 64-bit sum is always exact before the range check.
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int unsigned        w,
    input  bit                 sat,
    output logic               ovf
  );
    logic signed [63:0] s;
    logic signed [63:0] mx;
    logic signed [63:0] mn;
    s   = a + b;
    mx  = (64'sd1 <<< (w - 1)) - 64'sd1;
    mn  = -mx - 64'sd1;
    ovf = (s > mx) || (s < mn);
    if (!ovf) return s;
    if (sat) return (s > mx) ? mx : mn;
    return (s <<< (64 - w)) >>> (64 - w);
  endfunction

endpackage
`default_nettype wire

// File: rtl/systolic_pe_dual_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_pe_dual_if : control, activation and psum bus of one PE   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface systolic_pe_dual_if #(
  parameter int DATA_WIDTH             = 8,
  parameter int ACCUMULATOR_DATA_WIDTH = 32
);
  logic                                     EN;
  logic                                     MODE;
  logic                                     LOAD;
  logic                                     SWAP;
  logic                                     DRAIN;
  logic signed [DATA_WIDTH-1:0]             Input;
  logic                                     InValid;
  logic signed [DATA_WIDTH-1:0]             ToRight;
  logic                                     ToRightValid;
  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumIn;
  logic                                     PsumInValid;
  logic signed [ACCUMULATOR_DATA_WIDTH-1:0] PsumOut;
  logic                                     PsumOutValid;
  logic                                     OVF;
  logic                                     COLLIDE;

  modport slave (
    input  EN, MODE, LOAD, SWAP, DRAIN, Input, InValid, PsumIn, PsumInValid,
    output ToRight, ToRightValid, PsumOut, PsumOutValid, OVF, COLLIDE
  );

  modport master (
    output EN, MODE, LOAD, SWAP, DRAIN, Input, InValid, PsumIn, PsumInValid,
    input  ToRight, ToRightValid, PsumOut, PsumOutValid, OVF, COLLIDE
  );
endinterface
`default_nettype wire

// File: rtl/systolic_pe_dual_sat_mac.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_sat_mac : combinational signed multiply plus saturating add     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pe_sat_mac
  import pe_pkg::*;
#(
  parameter int DW  = 8,
  parameter int AW  = 32,
  parameter int SAT = 1
) (
  input  wire logic signed [DW-1:0] act_i,
  input  wire logic signed [DW-1:0] wgt_i,
  input  wire logic signed [AW-1:0] addend_i,
  output logic signed [AW-1:0]      sum_o,
  output logic                      ovf_o
);

  logic signed [2*DW-1:0] prod;

  assign prod = act_i * wgt_i;

  always_comb begin
    ovf_o = 1'b0;
    sum_o = AW'(sat_add(64'(prod), 64'(addend_i), AW, SAT != 0, ovf_o));
  end

endmodule
`default_nettype wire

// File: rtl/systolic_pe_dual.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | systolic_pe_dual : dual-dataflow (WS/OS) systolic PE with          |
// | double-buffered weight and optional saturating accumulation        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module systolic_pe_dual
  import pe_pkg::*;
#(
  parameter int DATA_WIDTH             = 8,
  parameter int ACCUMULATOR_DATA_WIDTH = 32,
  parameter int SATURATE               = 1
) (
  input wire logic          CLK,
  input wire logic          SYNC_RST,
  systolic_pe_dual_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ACCUMULATOR_DATA_WIDTH;

  pe_state_e             state_q, state_d;
  logic signed [DW-1:0]  shadow_q, active_q, to_right_q;
  logic                  to_right_valid_q;
  logic signed [AW-1:0]  acc_q, acc_d, psum_q, psum_d;
  logic                  psum_valid_q, psum_valid_d;
  logic                  ovf_q, ovf_d, collide_q, collide_d;
  logic signed [AW-1:0]  mac_addend, mac_sum;
  logic                  mac_ovf;

  // WS adds the incoming psum; OS adds the local accumulator.
  assign mac_addend = (state_q == OS_ACC) ? acc_q
                    : (bus.PsumInValid ? bus.PsumIn : '0);

  pe_sat_mac #(
    .DW  (DW),
    .AW  (AW),
    .SAT (SATURATE)
  ) u_mac (
    .act_i    (bus.Input),
    .wgt_i    (active_q),
    .addend_i (mac_addend),
    .sum_o    (mac_sum),
    .ovf_o    (mac_ovf)
  );

  always_ff @(posedge CLK) begin
    if (SYNC_RST) begin
      state_q          <= IDLE;
      shadow_q         <= '0;
      active_q         <= '0;
      to_right_q       <= '0;
      to_right_valid_q <= 1'b0;
      acc_q            <= '0;
      psum_q           <= '0;
      psum_valid_q     <= 1'b0;
      ovf_q            <= 1'b0;
      collide_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      to_right_q       <= bus.Input;
      to_right_valid_q <= bus.InValid;
      acc_q            <= acc_d;
      psum_q           <= psum_d;
      psum_valid_q     <= psum_valid_d;
      ovf_q            <= ovf_d;
      collide_q        <= collide_d;
      if (bus.LOAD && bus.SWAP) begin
        shadow_q <= bus.Input;
        active_q <= bus.Input;
      end else if (bus.LOAD) begin
        shadow_q <= bus.Input;
      end else if (bus.SWAP) begin
        active_q <= shadow_q;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    psum_d       = psum_q;
    psum_valid_d = 1'b0;
    ovf_d        = ovf_q;
    collide_d    = collide_q;
    case (state_q)
      IDLE: begin
        if (bus.EN) begin
          if (bus.MODE == MODE_OS) begin
            state_d = OS_ACC;
            acc_d   = '0;
          end else begin
            state_d = WS_RUN;
          end
        end
      end
      WS_RUN: begin
        if (!bus.EN) begin
          state_d = IDLE;
        end else if (bus.InValid) begin
          psum_d       = mac_sum;
          psum_valid_d = 1'b1;
          ovf_d        = ovf_q | mac_ovf;
        end else if (bus.PsumInValid) begin
          psum_d       = bus.PsumIn;
          psum_valid_d = 1'b1;
        end
      end
      OS_ACC: begin
        if (!bus.EN) begin
          state_d = IDLE;
        end else begin
          if (bus.InValid) begin
            acc_d = mac_sum;
            ovf_d = ovf_q | mac_ovf;
          end
          if (bus.PsumInValid) begin
            psum_d       = bus.PsumIn;
            psum_valid_d = 1'b1;
          end
          if (bus.DRAIN) begin
            state_d   = OS_DRAIN;
            collide_d = collide_q | bus.PsumInValid;
          end
        end
      end
      OS_DRAIN: begin
        psum_d       = acc_q;
        psum_valid_d = 1'b1;
        acc_d        = '0;
        collide_d    = collide_q | bus.PsumInValid;
        state_d      = bus.EN ? OS_ACC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ToRight      = to_right_q;
  assign bus.ToRightValid = to_right_valid_q;
  assign bus.PsumOut      = psum_q;
  assign bus.PsumOutValid = psum_valid_q;
  assign bus.OVF          = ovf_q;
  assign bus.COLLIDE      = collide_q;

endmodule
`default_nettype wire

// File: tb/tb_systolic_pe_dual.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_systolic_pe_dual : three PE configurations driven in lockstep,  |
// | checked against a behavioural model plus literal expectations      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_systolic_pe_dual;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic               s_rst = 1'b1, s_en = 1'b0, s_mode = 1'b0, s_load = 1'b0;
  logic               s_swap = 1'b0, s_drain = 1'b0, s_iv = 1'b0, s_piv = 1'b0;
  logic signed [7:0]  s_in = '0;
  logic signed [31:0] s_pin = '0;

  int n_tests = 0;
  int n_fail  = 0;

  systolic_pe_dual_if #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(32)) b0 ();
  systolic_pe_dual_if #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16)) b1 ();
  systolic_pe_dual_if #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16)) b2 ();

  assign b0.EN = s_en;   assign b1.EN = s_en;   assign b2.EN = s_en;
  assign b0.MODE = s_mode; assign b1.MODE = s_mode; assign b2.MODE = s_mode;
  assign b0.LOAD = s_load; assign b1.LOAD = s_load; assign b2.LOAD = s_load;
  assign b0.SWAP = s_swap; assign b1.SWAP = s_swap; assign b2.SWAP = s_swap;
  assign b0.DRAIN = s_drain; assign b1.DRAIN = s_drain; assign b2.DRAIN = s_drain;
  assign b0.Input = s_in; assign b1.Input = s_in; assign b2.Input = s_in;
  assign b0.InValid = s_iv; assign b1.InValid = s_iv; assign b2.InValid = s_iv;
  assign b0.PsumIn = s_pin; assign b1.PsumIn = s_pin[15:0]; assign b2.PsumIn = s_pin[15:0];
  assign b0.PsumInValid = s_piv; assign b1.PsumInValid = s_piv; assign b2.PsumInValid = s_piv;

  systolic_pe_dual #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(32), .SATURATE(1))
    u_dut0 (.CLK(CLK), .SYNC_RST(s_rst), .bus(b0));
  systolic_pe_dual #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16), .SATURATE(1))
    u_dut1 (.CLK(CLK), .SYNC_RST(s_rst), .bus(b1));
  systolic_pe_dual #(.DATA_WIDTH(8), .ACCUMULATOR_DATA_WIDTH(16), .SATURATE(0))
    u_dut2 (.CLK(CLK), .SYNC_RST(s_rst), .bus(b2));

  // ---------------- behavioural model ----------------
  int     W [3] = '{32, 16, 16};
  bit     S [3] = '{1'b1, 1'b1, 1'b0};
  longint m_tr[3], m_po[3], m_sh[3], m_act[3], m_acc[3];
  bit     m_trv[3], m_pov[3], m_ovf[3], m_col[3];
  int     m_ph[3];   // 0 idle, 1 ws run, 2 os accumulate, 3 os drain
  bit     m_ok = 1'b0;

  function automatic longint fit(input int w, input bit sat, input longint s, output bit o);
    longint hi, lo, span;
    hi   = (longint'(1) << (w - 1)) - 1;
    lo   = -hi - 1;
    span = longint'(1) << w;
    o    = 1'b0;
    if (s > hi) begin o = 1'b1; return sat ? hi : s - span; end
    if (s < lo) begin o = 1'b1; return sat ? lo : s + span; end
    return s;
  endfunction

  always @(posedge CLK) begin
    longint a, pin, prod, r;
    bit     o;
    for (int k = 0; k < 3; k++) begin
      if (s_rst) begin
        m_tr[k] = 0; m_trv[k] = 0; m_po[k] = 0; m_pov[k] = 0; m_ovf[k] = 0;
        m_col[k] = 0; m_sh[k] = 0; m_act[k] = 0; m_acc[k] = 0; m_ph[k] = 0;
      end else begin
        a    = longint'(s_in);
        pin  = (k == 0) ? longint'(s_pin) : longint'($signed(s_pin[15:0]));
        prod = a * m_act[k];
        m_tr[k]  = a;
        m_trv[k] = s_iv;
        m_pov[k] = 0;
        case (m_ph[k])
          0: if (s_en) begin
               m_ph[k] = s_mode ? 2 : 1;
               if (s_mode) m_acc[k] = 0;
             end
          1: if (!s_en) m_ph[k] = 0;
             else if (s_iv) begin
               r = fit(W[k], S[k], (s_piv ? pin : 0) + prod, o);
               m_po[k] = r; m_pov[k] = 1; m_ovf[k] |= o;
             end else if (s_piv) begin
               m_po[k] = pin; m_pov[k] = 1;
             end
          2: if (!s_en) m_ph[k] = 0;
             else begin
               if (s_iv) begin
                 m_acc[k] = fit(W[k], S[k], m_acc[k] + prod, o);
                 m_ovf[k] |= o;
               end
               if (s_piv) begin m_po[k] = pin; m_pov[k] = 1; end
               if (s_drain) begin m_ph[k] = 3; if (s_piv) m_col[k] = 1; end
             end
          default: begin
               m_po[k] = m_acc[k]; m_pov[k] = 1; m_acc[k] = 0;
               if (s_piv) m_col[k] = 1;
               m_ph[k] = s_en ? 2 : 0;
             end
        endcase
        if (s_load && s_swap) begin m_sh[k] = a; m_act[k] = a; end
        else if (s_load) m_sh[k] = a;
        else if (s_swap) m_act[k] = m_sh[k];
      end
    end
    if (s_rst) m_ok = 1'b1;
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_one(input int k, input logic signed [63:0] tr, input logic trv,
                         input logic signed [63:0] po, input logic pov,
                         input logic ovf, input logic col);
    chk($sformatf("dut%0d.ToRight", k),      tr,  m_tr[k]);
    chk($sformatf("dut%0d.ToRightValid", k), 64'(trv), 64'(m_trv[k]));
    chk($sformatf("dut%0d.PsumOut", k),      po,  m_po[k]);
    chk($sformatf("dut%0d.PsumOutValid", k), 64'(pov), 64'(m_pov[k]));
    chk($sformatf("dut%0d.OVF", k),          64'(ovf), 64'(m_ovf[k]));
    chk($sformatf("dut%0d.COLLIDE", k),      64'(col), 64'(m_col[k]));
  endtask

  always @(negedge CLK) begin
    if (m_ok) begin
      cmp_one(0, $signed(b0.ToRight), b0.ToRightValid, $signed(b0.PsumOut), b0.PsumOutValid, b0.OVF, b0.COLLIDE);
      cmp_one(1, $signed(b1.ToRight), b1.ToRightValid, $signed(b1.PsumOut), b1.PsumOutValid, b1.OVF, b1.COLLIDE);
      cmp_one(2, $signed(b2.ToRight), b2.ToRightValid, $signed(b2.PsumOut), b2.PsumOutValid, b2.OVF, b2.COLLIDE);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset and first WS MAC: 4*50 + 1
    cyc(); cyc();
    chk("rst PsumOut", $signed(b0.PsumOut), 0);
    chk("rst PsumOutValid", 64'(b0.PsumOutValid), 0);
    chk("rst OVF", 64'(b0.OVF), 0);
    s_rst = 1'b0; s_load = 1'b1; s_in = 8'sd50; cyc();
    s_load = 1'b0; s_swap = 1'b1; cyc();
    s_swap = 1'b0; s_en = 1'b1; s_mode = 1'b0; s_in = 8'sd4; s_iv = 1'b1;
    s_pin = 32'sd1; s_piv = 1'b1; cyc();
    chk("fwd ToRight", $signed(b0.ToRight), 4);
    chk("idle PsumOutValid", 64'(b0.PsumOutValid), 0);
    cyc();
    chk("ws first PsumOut", $signed(b0.PsumOut), 201);
    chk("ws first PsumOutValid", 64'(b0.PsumOutValid), 1);

    // Shadow weight loaded while computing
    s_load = 1'b1; s_in = 8'sd3; s_iv = 1'b0; s_piv = 1'b0; cyc();
    chk("ws idle cycle valid", 64'(b0.PsumOutValid), 0);
    s_load = 1'b0; s_swap = 1'b1; cyc();
    s_swap = 1'b0; s_load = 1'b1; s_in = 8'sd7; s_iv = 1'b1; s_pin = 0; s_piv = 1'b1; cyc();
    chk("ws old weight", $signed(b0.PsumOut), 21);
    s_load = 1'b0; s_swap = 1'b1; s_iv = 1'b0; s_piv = 1'b0; cyc();
    s_swap = 1'b0; s_in = 8'sd2; s_iv = 1'b1; s_piv = 1'b1; cyc();
    chk("ws after swap", $signed(b0.PsumOut), 14);
    s_load = 1'b1; s_swap = 1'b1; s_in = -8'sd5; s_piv = 1'b0; cyc();
    chk("ws load+swap cycle", $signed(b0.PsumOut), -35);
    s_load = 1'b0; s_swap = 1'b0; s_in = 8'sd2; cyc();
    chk("ws new weight -5", $signed(b0.PsumOut), -10);

    // OS accumulate and drain
    s_en = 1'b0; s_iv = 1'b0; s_in = 0; cyc();
    s_load = 1'b1; s_in = -8'sd2; cyc();
    s_load = 1'b0; s_swap = 1'b1; cyc();
    s_swap = 1'b0; s_en = 1'b1; s_mode = 1'b1; cyc();
    s_iv = 1'b1; s_in = 8'sd1; cyc();
    s_in = 8'sd2; cyc();
    s_in = 8'sd3; cyc();
    s_iv = 1'b0; s_drain = 1'b1; cyc();
    s_drain = 1'b0; cyc();
    chk("os drain PsumOut", $signed(b0.PsumOut), -12);
    chk("os drain valid", 64'(b0.PsumOutValid), 1);
    cyc();
    chk("os drain one cycle", 64'(b0.PsumOutValid), 0);
    s_drain = 1'b1; cyc();
    s_drain = 1'b0; cyc();
    chk("os empty drain", $signed(b0.PsumOut), 0);

    // Pass-through and collision
    s_pin = 32'sd99; s_piv = 1'b1; cyc();
    chk("os pass PsumOut", $signed(b0.PsumOut), 99);
    chk("os pass no collide", 64'(b0.COLLIDE), 0);
    s_drain = 1'b1; cyc();
    chk("collide set", 64'(b0.COLLIDE), 1);
    s_drain = 1'b0; s_piv = 1'b0; cyc(); cyc();
    chk("collide sticky", 64'(b0.COLLIDE), 1);

    // Saturation and wrap at 16 bits
    s_rst = 1'b1; s_en = 1'b0; s_mode = 1'b0; cyc();
    chk("rst clears collide", 64'(b0.COLLIDE), 0);
    s_rst = 1'b0; s_load = 1'b1; s_swap = 1'b1; s_in = 8'sd127; cyc();
    s_load = 1'b0; s_swap = 1'b0; s_en = 1'b1; cyc();
    s_iv = 1'b1; s_pin = 32'sd32000; s_piv = 1'b1; cyc();
    chk("sat16 high", $signed(b1.PsumOut), 32767);
    chk("sat16 OVF", 64'(b1.OVF), 1);
    chk("wrap16 high", $signed(b2.PsumOut), -17407);
    chk("wrap16 OVF", 64'(b2.OVF), 1);
    chk("acc32 exact", $signed(b0.PsumOut), 48129);
    chk("acc32 no OVF", 64'(b0.OVF), 0);
    s_in = 8'h80; s_pin = -32'sd32000; cyc();
    chk("sat16 low", $signed(b1.PsumOut), -32768);
    chk("wrap16 low", $signed(b2.PsumOut), 17280);
    chk("acc32 low", $signed(b0.PsumOut), -48256);

    // Reset in the middle of an OS accumulation
    s_en = 1'b0; s_iv = 1'b0; s_piv = 1'b0; cyc();
    s_en = 1'b1; s_mode = 1'b1; cyc();
    s_in = 8'sd5; s_iv = 1'b1; cyc();
    s_rst = 1'b1; cyc();
    chk("midrst ToRight", $signed(b0.ToRight), 0);
    chk("midrst ToRightValid", 64'(b0.ToRightValid), 0);
    chk("midrst PsumOut", $signed(b0.PsumOut), 0);
    chk("midrst OVF", 64'(b1.OVF), 0);
    s_rst = 1'b0; s_iv = 1'b0; cyc();
    s_iv = 1'b1; cyc();
    s_iv = 1'b0; s_drain = 1'b1; cyc();
    s_drain = 1'b0; cyc();
    chk("midrst weights cleared", $signed(b0.PsumOut), 0);
    chk("midrst drain valid", 64'(b0.PsumOutValid), 1);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      s_rst   = ($urandom_range(0, 99) == 0);
      s_en    = ($urandom_range(0, 15) != 0);
      s_mode  = 1'($urandom_range(0, 1));
      s_load  = ($urandom_range(0, 7) == 0);
      s_swap  = ($urandom_range(0, 7) == 0);
      s_drain = ($urandom_range(0, 5) == 0);
      s_in    = 8'($urandom);
      s_iv    = 1'($urandom_range(0, 1));
      s_piv   = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: s_pin = 32'sh7FFF_C000 + 32'($urandom_range(0, 16383));
        1: s_pin = 32'sh8000_0000 + 32'($urandom_range(0, 16383));
        default: s_pin = 32'($urandom);
      endcase
      cyc();
    end

    s_rst = 1'b1; cyc(); cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
